// File: rtl/fifo_status_if.sv
// Handshake and status bundle for fifo_status.
// master drives writes, reads and err_clr; slave returns head data, flags and occupancy.
interface fifo_status_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4
);
    logic [DATA_SIZE-1:0] data_in;
    logic                 w_e;
    logic                 r_ack;
    logic                 err_clr;
    logic [DATA_SIZE-1:0] data_out;
    logic                 empty;
    logic                 full;
    logic                 almost_full;
    logic [ADDR_SIZE:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output data_in, w_e, r_ack, err_clr,
        input  data_out, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  data_in, w_e, r_ack, err_clr,
        output data_out, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_status.sv
// Synchronous FWFT FIFO with occupancy and status flags; optional sticky errors under FIFO_ERR_EN.
// Latency: a word written into an empty FIFO appears on data_out right after its write edge.
// Backpressure: writes are dropped while full unless a read is accepted in the same cycle.
module fifo_status #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int AF_LEVEL  = 12
) (
    input  logic          clk,
    input  logic          nRST,
    fifo_status_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] PTR_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0] DEPTH_CNT = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0] AF_CNT    = (ADDR_SIZE+1)'(AF_LEVEL);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0] count_q,  count_d;
    logic               empty_q,  empty_d;
    logic               full_q,   full_d;
    logic               afull_q,  afull_d;
    logic               wr_acc;
    logic               rd_acc;

    always_comb begin
        rd_acc   = bus.r_ack && !empty_q;
        wr_acc   = bus.w_e && (!full_q || rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
        // Flags are registered from next-state values so they move only on an edge.
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (count_d == DEPTH_CNT);
        afull_d  = (count_d >= AF_CNT);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

    // Storage is deliberately left out of reset; empty masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= bus.data_in;
        end
    end

    assign bus.data_out    = empty_q ? '0 : mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.count       = count_q;

`ifdef FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        ovf_d = (bus.w_e && full_q && !rd_acc) || (ovf_q && !bus.err_clr);
        unf_d = (bus.r_ack && empty_q) || (unf_q && !bus.err_clr);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status (32x16, almost-full at 12); error flags expected set only with FIFO_ERR_EN.
module tb_fifo_status;
    logic clk;
    logic nRST;
    int   n_total;
    int   n_pass;

`ifdef FIFO_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    fifo_status_if #(.DATA_SIZE(32), .ADDR_SIZE(4)) bus ();

    fifo_status #(.DATA_SIZE(32), .ADDR_SIZE(4), .AF_LEVEL(12)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        nRST        = 1'b0;
        bus.data_in = '0;
        bus.w_e     = 1'b0;
        bus.r_ack   = 1'b0;
        bus.err_clr = 1'b0;

        // Reset state
        #13;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_unf", bus.underflow, 0);
        #4 nRST = 1'b1;

        // Fill with 1..16
        for (int i = 1; i <= 16; i++) begin
            bus.w_e = 1'b1;
            bus.data_in = i;
            tick();
            chk("fill_count", bus.count, i);
            chk("fill_af", bus.almost_full, (i >= 12));
            chk("fill_full", bus.full, (i == 16));
            chk("fill_dout", bus.data_out, 1);
        end

        // Write while full is rejected
        bus.data_in = 99;
        tick();
        bus.w_e = 1'b0;
        chk("ovf_count", bus.count, 16);
        chk("ovf_dout", bus.data_out, 1);
        chk("ovf_flag", bus.overflow, ERR_ON);
        tick();
        chk("ovf_hold", bus.overflow, ERR_ON);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("ovf_clr", bus.overflow, 0);

        // Simultaneous push/pop while full, crossing pointer wrap
        for (int i = 1; i <= 20; i++) begin
            bus.w_e = 1'b1;
            bus.r_ack = 1'b1;
            bus.data_in = 16 + i;
            chk("pp_head", bus.data_out, i);
            tick();
            chk("pp_count", bus.count, 16);
            chk("pp_full", bus.full, 1);
        end
        bus.w_e = 1'b0;
        chk("pp_ovf", bus.overflow, 0);
        chk("pp_next", bus.data_out, 21);

        // Drain 21..36
        for (int k = 0; k < 16; k++) begin
            bus.r_ack = 1'b1;
            chk("drain_head", bus.data_out, 21 + k);
            tick();
            chk("drain_count", bus.count, 15 - k);
            chk("drain_af", bus.almost_full, ((15 - k) >= 12));
        end
        chk("drain_empty", bus.empty, 1);
        chk("drain_dout", bus.data_out, 0);

        // Read on empty
        tick();
        chk("unf_count", bus.count, 0);
        chk("unf_dout", bus.data_out, 0);
        chk("unf_flag", bus.underflow, ERR_ON);
        bus.err_clr = 1'b1;
        tick();
        chk("unf_set_wins", bus.underflow, ERR_ON);
        bus.r_ack = 1'b0;
        tick();
        chk("unf_clr", bus.underflow, 0);
        bus.err_clr = 1'b0;

        // Push and pop together on empty: only the write lands
        bus.w_e = 1'b1;
        bus.r_ack = 1'b1;
        bus.data_in = 55;
        tick();
        bus.w_e = 1'b0;
        bus.r_ack = 1'b0;
        chk("ewr_count", bus.count, 1);
        chk("ewr_dout", bus.data_out, 55);
        chk("ewr_empty", bus.empty, 0);
        chk("ewr_unf", bus.underflow, ERR_ON);
        bus.err_clr = 1'b1;
        bus.r_ack = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        bus.r_ack = 1'b0;
        chk("ewr_pop_empty", bus.empty, 1);
        chk("ewr_unf_clr", bus.underflow, 0);

        // Mid-operation async reset
        for (int i = 0; i < 5; i++) begin
            bus.w_e = 1'b1;
            bus.data_in = 101 + i;
            tick();
        end
        chk("pre_rst_count", bus.count, 5);
        bus.data_in = 200;
        #2 nRST = 1'b0;
        #1;
        chk("arst_empty", bus.empty, 1);
        chk("arst_count", bus.count, 0);
        chk("arst_dout", bus.data_out, 0);
        tick();
        chk("arst_ignore", bus.count, 0);
        nRST = 1'b1;
        bus.data_in = 7;
        tick();
        bus.w_e = 1'b0;
        chk("post_rst_dout", bus.data_out, 7);
        chk("post_rst_count", bus.count, 1);
        bus.r_ack = 1'b1;
        tick();
        bus.r_ack = 1'b0;
        chk("post_rst_empty", bus.empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
